hub75_column_driver: RTL and testbench
======================================

# hub75_column_driver

Consumer side of the column-frame interface: requests column pairs from the frame generator by index, captures the returned pixel data, and serialises it onto the HUB75 panel pins. Colour depth comes from binary-coded modulation (BCM). The block sits between the frame generator (e.g. the boids frame) and the physical LED panel on the spinning rotor. It owns all panel timing: shift clock, latch, output enable and row address.

## Interface
- SCAN_RATE, 32: panel addresses; one address drives two pixel lines (column1, column2).
- NUM_ROWS, 64: pixels per column.
- RGB_RES, 9: bits per pixel, packed R[8:6] G[5:3] B[2:0]; BITS = RGB_RES/3.
- BASE_ON, 8: on-time in cycles of BCM plane 0.
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- sync_in  input  1  single-cycle pulse (period_ready); restart the scan at address 0.
- column_index1  output  $clog2(SCAN_RATE)  requested column for half 1.
- column_index2  output  $clog2(SCAN_RATE)  requested column for half 2; always equal to column_index1.
- columns  input  [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  pixel data; valid one cycle after the index changes.
- r1, g1, b1, r2, g2, b2  output  1 each  panel serial data.
- panel_clk  output  1  panel shift clock.
- latch  output  1  panel latch strobe.
- oe_n  output  1  panel output enable, active low.
- addr  output  $clog2(SCAN_RATE)  panel row address.

## Operation
- States: FETCH, SHIFT, LATCH, DISPLAY, BLANK.
- FETCH, 2 cycles:
  - Cycle 0: drive column_index = next address.
  - Cycle 1: register all of columns into a local buffer. Set plane = 0.
- SHIFT, 2*NUM_ROWS cycles:
  - Pixels go out from index NUM_ROWS-1 down to 0.
  - Per pixel: cycle A, panel_clk=0 and data bits = bit `plane` of the R/G/B field of buffer[0] and buffer[1]; cycle B, panel_clk=1 with data held.
- LATCH, 1 cycle: latch=1, oe_n=1. addr updates to the buffered address in this cycle.
- DISPLAY: oe_n=0 for BASE_ON<<plane cycles.
- BLANK, 1 cycle: oe_n=1.
  - If plane<BITS-1: plane+1, go to SHIFT.
  - Otherwise: address+1 (wraps SCAN_RATE-1 → 0), go to FETCH.
- sync_in: sets a pending flag. At the next address advance, the next address becomes 0 instead of address+1, and the flag clears.
  - sync_in during that same advancing BLANK cycle: consumed immediately.
  - Repeated pulses before consumption: collapse into one.
- Reset: state FETCH, address 0, plane 0, pending flag clear.
  - Output reset values: data 0, panel_clk 0, latch 0, oe_n 1, addr 0, column_index1/2 0.
  - Reset mid-shift or mid-display: abandons the cycle immediately, with oe_n=1 in the next cycle.

## Timing
- All outputs registered; no combinational path from columns to pins.
- oe_n is 1 in every cycle where latch=1 or addr changes.
- Cycles per address: 2 + sum over planes of (2*NUM_ROWS + 2 + (BASE_ON<<plane)).
  - Defaults: 2 + 138 + 146 + 162 = 448 cycles.
- columns must stay stable only during FETCH cycle 1.

## Configuration
- HUB75_BCM_EN defined: full BCM with BITS planes, as above.
- HUB75_BCM_EN undefined: a single plane using the MSB of each colour field.
  - DISPLAY lasts BASE_ON<<(BITS-1) cycles.
  - Defaults: 2 + 130 + 32 = 164 cycles per address.

## Structure
- hub75_pkg holds:
  - the state enum;
  - the pixel field offsets (R_OFS=6, G_OFS=3, B_OFS=0);
  - a function giving the display length for a plane.
- Sub-module hub75_shifter: owns the column buffer, pixel counter and panel_clk toggle. Controls are start/done, and it takes plane as an input.

## Test plan
- Reset, then release with defaults: oe_n=1, addr=0, column_index1=0. First panel_clk rising edge at cycle 3.
- Buffer all pixels = 9'b101_010_111 (BCM on):
  - plane 0 shifts r=1, g=0, b=1;
  - plane 1 shifts r=0, g=1, b=1;
  - plane 2 shifts r=1, g=0, b=1.
  - DISPLAY lengths are 8, 16 and 32 cycles.
- Free run: addresses step 0→1→…→31→0. column_index advances every 448 cycles, and oe_n=1 whenever addr changes.
- sync_in pulsed during address 5 SHIFT: the next FETCH requests index 0, not 6. Two pulses in one address give the same single restart.
- Reset asserted mid-DISPLAY: oe_n=1 the next cycle and latch=0. After release, the scan resumes from FETCH with index 0.
- HUB75_BCM_EN undefined, pixel MSBs = 1: one latch per address, 32-cycle DISPLAY, 164 cycles per address.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM states, pixel field offsets and BCM display timing
// No ports; imported by hub75_column_driver and hub75_shifter.
package hub75_pkg;

    typedef enum logic [2:0] {FETCH, FETCH_CAP, SHIFT, LATCH, DISPLAY, BLANK} state_t;

    localparam int R_OFS = 6;
    localparam int G_OFS = 3;
    localparam int B_OFS = 0;

    function automatic int display_len(input int base_on, input int plane);
        return base_on << plane;
    endfunction

endpackage

// File: rtl/hub75_column_driver_if.sv
// hub75_column_driver_if: column-frame request/response bus
// column_index1/2 : requested column for each panel half (driven by master)
// columns         : pixel data for both halves, valid one cycle after the index changes
// master = column driver (consumer), slave = frame generator
interface hub75_column_driver_if #(
    parameter int SCAN_RATE = 32,
    parameter int NUM_ROWS  = 64,
    parameter int RGB_RES   = 9
);

    logic [$clog2(SCAN_RATE)-1:0]          column_index1;
    logic [$clog2(SCAN_RATE)-1:0]          column_index2;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns;

    modport master (output column_index1, output column_index2, input columns);
    modport slave  (input column_index1, input column_index2, output columns);

endinterface

// File: rtl/hub75_shifter.sv
// hub75_shifter: column buffer plus serialiser onto the HUB75 data/clock pins
// start   : begin shifting a plane next cycle (pixel NUM_ROWS-1 first)
// load    : capture columns into the buffer (same cycle as the first start)
// plane   : bit plane to shift, valid on the start cycle and throughout the shift
// done    : high in the last shift cycle (panel_clk high of pixel 0)
// r1..b2, panel_clk : registered panel pins
module hub75_shifter
    import hub75_pkg::*;
#(
    parameter int NUM_ROWS = 64,
    parameter int RGB_RES  = 9,
    parameter int PW       = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start,
    input  logic                                  load,
    input  logic [PW-1:0]                         plane,
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
    output logic                                  done,
    output logic                                  r1,
    output logic                                  g1,
    output logic                                  b1,
    output logic                                  r2,
    output logic                                  g2,
    output logic                                  b2,
    output logic                                  panel_clk
);

    localparam int IW = $clog2(NUM_ROWS);

    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] col_buf;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] src;
    logic [IW-1:0]                         pix;
    logic [IW-1:0]                         sel;
    logic [RGB_RES-1:0]                    p1;
    logic [RGB_RES-1:0]                    p2;
    logic [5:0]                            bits;
    logic                                  busy;

    // The first pixel is registered on the capture edge, so it is taken
    // straight from columns; every later pixel comes from the buffer.
    always_comb begin
        src  = load ? columns : col_buf;
        sel  = start ? IW'(NUM_ROWS - 1) : pix - 1'b1;
        p1   = src[0][sel] >> plane;
        p2   = src[1][sel] >> plane;
        bits = {p1[R_OFS], p1[G_OFS], p1[B_OFS], p2[R_OFS], p2[G_OFS], p2[B_OFS]};
        done = busy && panel_clk && pix == '0;
    end

    always_ff @(posedge clk_in) begin
        if (load)
            col_buf <= columns;
    end

    // panel_clk doubles as the pixel phase: low = data set up, high = shift.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy                       <= 1'b0;
            pix                        <= '0;
            panel_clk                  <= 1'b0;
            {r1, g1, b1, r2, g2, b2}   <= '0;
        end else if (start) begin
            busy                       <= 1'b1;
            pix                        <= IW'(NUM_ROWS - 1);
            panel_clk                  <= 1'b0;
            {r1, g1, b1, r2, g2, b2}   <= bits;
        end else if (busy) begin
            panel_clk                  <= !panel_clk;
            busy                       <= !done;
            if (panel_clk && pix != '0) begin
                pix                    <= pix - 1'b1;
                {r1, g1, b1, r2, g2, b2} <= bits;
            end
        end
    end

endmodule

// File: rtl/hub75_column_driver.sv
// hub75_column_driver: fetches column pairs and drives a HUB75 panel with BCM
// clk_in, rst_in : clock, synchronous active-high reset
// sync_in        : period pulse; the next address advance restarts at 0
// col            : column request bus (master side)
// r1..b2, panel_clk, latch, oe_n, addr : registered panel pins
// HUB75_BCM_EN defined: BITS bit planes; undefined: MSB plane only.
module hub75_column_driver
    import hub75_pkg::*;
#(
    parameter int SCAN_RATE = 32,
    parameter int NUM_ROWS  = 64,
    parameter int RGB_RES   = 9,
    parameter int BASE_ON   = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         sync_in,
    hub75_column_driver_if.master        col,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic                         r2,
    output logic                         g2,
    output logic                         b2,
    output logic                         panel_clk,
    output logic                         latch,
    output logic                         oe_n,
    output logic [$clog2(SCAN_RATE)-1:0] addr
);

    localparam int AW   = $clog2(SCAN_RATE);
    localparam int BITS = RGB_RES / 3;
    localparam int PW   = BITS > 1 ? $clog2(BITS) : 1;
    localparam int CW   = 16;
`ifdef HUB75_BCM_EN
    localparam logic [PW-1:0] FIRST_PLANE = '0;
`else
    localparam logic [PW-1:0] FIRST_PLANE = PW'(BITS - 1);
`endif

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] address;
    logic [PW-1:0] plane;
    logic [PW-1:0] plane_d;
    logic [CW-1:0] cnt;
    logic          pend;
    logic          last;
    logic          adv;
    logic          start;
    logic          load;
    logic          done;

    always_comb begin
        last    = plane == PW'(BITS - 1);
        adv     = state == BLANK && last;
        start   = state == FETCH_CAP || (state == BLANK && !last);
        load    = state == FETCH_CAP;
        state_d = state;
        plane_d = plane;
        case (state)
            FETCH:     state_d = FETCH_CAP;
            FETCH_CAP: begin
                state_d = SHIFT;
                plane_d = FIRST_PLANE;
            end
            SHIFT:     state_d = done ? LATCH : SHIFT;
            LATCH:     state_d = DISPLAY;
            DISPLAY:   state_d = cnt == '0 ? BLANK : DISPLAY;
            BLANK:     begin
                state_d = last ? FETCH : SHIFT;
                plane_d = last ? plane : plane + 1'b1;
            end
            default:   state_d = FETCH;
        endcase
    end

    // Pins are registered from the next state so they line up with the state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= FETCH;
            address <= '0;
            plane   <= '0;
            pend    <= 1'b0;
            cnt     <= '0;
            latch   <= 1'b0;
            oe_n    <= 1'b1;
            addr    <= '0;
        end else begin
            state <= state_d;
            plane <= plane_d;
            pend  <= !adv && (pend || sync_in);
            if (adv)
                address <= (pend || sync_in || address == AW'(SCAN_RATE - 1)) ? '0 : address + 1'b1;
            cnt   <= state == LATCH ? CW'(display_len(BASE_ON, int'(plane)) - 1) : cnt - 1'b1;
            latch <= state_d == LATCH;
            oe_n  <= state_d != DISPLAY;
            if (state_d == LATCH)
                addr <= address;
        end
    end

    assign col.column_index1 = address;
    assign col.column_index2 = address;

    hub75_shifter #(
        .NUM_ROWS (NUM_ROWS),
        .RGB_RES  (RGB_RES),
        .PW       (PW)
    ) u_shifter (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (start),
        .load      (load),
        .plane     (plane_d),
        .columns   (col.columns),
        .done      (done),
        .r1        (r1),
        .g1        (g1),
        .b1        (b1),
        .r2        (r2),
        .g2        (g2),
        .b2        (b2),
        .panel_clk (panel_clk)
    );

endmodule

// File: tb/tb_hub75_column_driver.sv
// tb_hub75_column_driver: scoreboard bench for hub75_column_driver
module tb_hub75_column_driver;

    localparam int SCAN_RATE = 32;
    localparam int NUM_ROWS  = 64;
    localparam int RGB_RES   = 9;
    localparam int BASE_ON   = 8;
`ifdef HUB75_BCM_EN
    localparam int NP  = 3;
    localparam int P0  = 0;
    localparam int CPA = 448;
`else
    localparam int NP  = 1;
    localparam int P0  = 2;
    localparam int CPA = 164;
`endif

    typedef struct packed {
        logic [4:0]                idx;
        logic [15:0]               len;
        logic [NUM_ROWS-1:0][5:0]  bits;
    } exp_t;

    logic       clk_in  = 1'b0;
    logic       rst_in  = 1'b1;
    logic       sync_in = 1'b0;
    logic       r1, g1, b1, r2, g2, b2, panel_clk, latch, oe_n;
    logic [4:0] addr;
    int         n_cmp = 0;
    int         n_err = 0;
    int         mode  = 0;
    exp_t       sb[$];

    int                       m_last = -1;
    int                       m_k = 0;
    int                       m_dcnt = 0;
    int                       m_len = 0;
    int                       m_exp_i = 0;
    bit                       m_pend = 0;
    bit                       m_disp = 0;
    logic                     m_prev_clk = 1'b0;
    logic [4:0]               m_prev_addr = '0;
    logic [NUM_ROWS-1:0][5:0] m_got;
    exp_t                     m_e;

    hub75_column_driver_if #(.SCAN_RATE(SCAN_RATE), .NUM_ROWS(NUM_ROWS), .RGB_RES(RGB_RES)) cif ();

    hub75_column_driver #(
        .SCAN_RATE (SCAN_RATE),
        .NUM_ROWS  (NUM_ROWS),
        .RGB_RES   (RGB_RES),
        .BASE_ON   (BASE_ON)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sync_in   (sync_in),
        .col       (cif),
        .r1        (r1),
        .g1        (g1),
        .b1        (b1),
        .r2        (r2),
        .g2        (g2),
        .b2        (b2),
        .panel_clk (panel_clk),
        .latch     (latch),
        .oe_n      (oe_n),
        .addr      (addr)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pix_val(int h, int row, int idx, int m);
        if (m == 0)
            return h == 0 ? 9'b101_010_111 : 9'b010_101_000;
        return 9'((row * 37 + idx * 11 + h * 101) ^ (row << 3));
    endfunction

    function automatic logic [5:0] exp_bits(logic [8:0] a, logic [8:0] b, int p);
        logic [8:0] sa;
        logic [8:0] sbb;
        sa  = a >> p;
        sbb = b >> p;
        return {sa[6], sa[3], sa[0], sbb[6], sbb[3], sbb[0]};
    endfunction

    // Column source + scoreboard: drives columns when a new index is requested
    // and pushes one expectation per bit plane; pops on every latch.
    initial begin
        cif.columns = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_in) begin
                sb.delete();
                m_last = -1;
                m_pend = 0;
                m_k = 0;
                m_disp = 0;
                m_prev_clk = panel_clk;
                m_prev_addr = addr;
                continue;
            end
            if (int'(cif.column_index1) != m_last) begin
                m_exp_i = (m_last < 0 || m_pend || sync_in) ? 0 : (m_last + 1) % SCAN_RATE;
                check("column_index1", 64'(cif.column_index1), 64'(m_exp_i));
                check("column_index2", 64'(cif.column_index2), 64'(m_exp_i));
                m_pend = 0;
                m_last = int'(cif.column_index1);
                for (int h = 0; h < 2; h++)
                    for (int r = 0; r < NUM_ROWS; r++)
                        cif.columns[h][r] = pix_val(h, r, m_last, mode);
                for (int p = P0; p < 3; p++) begin
                    m_e.idx = 5'(m_last);
                    m_e.len = 16'(BASE_ON << p);
                    for (int r = 0; r < NUM_ROWS; r++)
                        m_e.bits[r] = exp_bits(pix_val(0, r, m_last, mode), pix_val(1, r, m_last, mode), p);
                    sb.push_back(m_e);
                end
            end else if (sync_in) begin
                m_pend = 1;
            end
            if (panel_clk && !m_prev_clk) begin
                if (m_k < NUM_ROWS)
                    m_got[NUM_ROWS - 1 - m_k] = {r1, g1, b1, r2, g2, b2};
                m_k++;
            end
            m_prev_clk = panel_clk;
            if (addr != m_prev_addr)
                check("oe_n_on_addr_change", 64'(oe_n), 64'd1);
            m_prev_addr = addr;
            if (latch) begin
                check("oe_n_in_latch", 64'(oe_n), 64'd1);
                if (sb.size() == 0) begin
                    check("scoreboard_nonempty", 64'(sb.size()), 64'(NP));
                end else begin
                    m_e = sb.pop_front();
                    check("latched_addr", 64'(addr), 64'(m_e.idx));
                    check("pixels_per_plane", 64'(m_k), 64'(NUM_ROWS));
                    n_cmp++;
                    assert (m_got === m_e.bits) else begin
                        n_err++;
                        $error("FAIL shift_data addr %0d: observed %h expected %h", m_e.idx, m_got, m_e.bits);
                    end
                    m_len = int'(m_e.len);
                    m_disp = 1;
                    m_dcnt = 0;
                end
                m_k = 0;
            end else if (m_disp) begin
                if (!oe_n) begin
                    m_dcnt++;
                end else begin
                    check("display_len", 64'(m_dcnt), 64'(m_len));
                    m_disp = 0;
                end
            end
        end
    end

    task automatic measure(output int cyc, output int nl);
        logic [4:0] s;
        s = cif.column_index1;
        cyc = 0;
        nl = 0;
        do begin
            @(negedge clk_in);
            cyc++;
            nl += int'(latch);
        end while (cif.column_index1 == s && cyc < 2 * CPA);
    endtask

    task automatic wait_idx(input int t, input int budget);
        int n;
        n = 0;
        while (int'(cif.column_index1) != t && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("wait_idx", 64'(cif.column_index1), 64'(t));
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        @(negedge clk_in);
        sync_in = 1'b0;
    endtask

    initial begin
        int cyc;
        int nl;
        repeat (3) @(negedge clk_in);
        check("rst_oe_n", 64'(oe_n), 64'd1);
        check("rst_latch", 64'(latch), 64'd0);
        check("rst_panel_clk", 64'(panel_clk), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_index1", 64'(cif.column_index1), 64'd0);
        check("rst_index2", 64'(cif.column_index2), 64'd0);
        check("rst_data", 64'({r1, g1, b1, r2, g2, b2}), 64'd0);
        rst_in = 1'b0;
        check("c0_oe_n", 64'(oe_n), 64'd1);
        check("c0_index", 64'(cif.column_index1), 64'd0);
        @(negedge clk_in);
        check("c1_panel_clk", 64'(panel_clk), 64'd0);
        @(negedge clk_in);
        check("c2_panel_clk", 64'(panel_clk), 64'd0);
        @(negedge clk_in);
        check("c3_panel_clk", 64'(panel_clk), 64'd1);
        check("c3_oe_n", 64'(oe_n), 64'd1);
        measure(cyc, nl);
        check("first_addr_cycles", 64'(cyc + 3), 64'(CPA));
        check("first_addr_latches", 64'(nl), 64'(NP));
        measure(cyc, nl);
        check("addr_cycles", 64'(cyc), 64'(CPA));
        check("addr_latches", 64'(nl), 64'(NP));
        mode = 1;
        wait_idx(31, 32 * CPA);
        wait_idx(0, 2 * CPA);
        wait_idx(5, 6 * CPA);
        repeat (20) @(negedge clk_in);
        pulse_sync();
        repeat (100) @(negedge clk_in);
        pulse_sync();
        measure(cyc, nl);
        check("sync_restart_idx", 64'(cif.column_index1), 64'd0);
        measure(cyc, nl);
        check("single_restart_idx", 64'(cif.column_index1), 64'd1);
        check("single_restart_cycles", 64'(cyc), 64'(CPA));
        wait_idx(3, 4 * CPA);
        cyc = 0;
        while (oe_n && cyc < CPA) begin
            @(negedge clk_in);
            cyc++;
        end
        check("display_reached", 64'(oe_n), 64'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("midrst_oe_n", 64'(oe_n), 64'd1);
        check("midrst_latch", 64'(latch), 64'd0);
        check("midrst_panel_clk", 64'(panel_clk), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        check("midrst_index", 64'(cif.column_index1), 64'd0);
        measure(cyc, nl);
        check("post_rst_cycles", 64'(cyc), 64'(CPA));
        check("post_rst_idx", 64'(cif.column_index1), 64'd1);
        measure(cyc, nl);
        check("post_rst_idx2", 64'(cif.column_index1), 64'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
